// File: rtl/run_ctrl_if.sv
// Load/run port bundle between the run controller and its host/core side.
// master drives the request, load stream and core completion; slave is run_ctrl.
interface run_ctrl_if #(
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          start;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          core_reset;
    logic          core_done;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycles;

    modport master (
        output start, ld_len, ld_valid, ld_data, core_done,
        input  ld_ready, mem_we, mem_addr, mem_wdata, core_reset,
               busy, finished, timeout, cycles
    );

    modport slave (
        input  start, ld_len, ld_valid, ld_data, core_done,
        output ld_ready, mem_we, mem_addr, mem_wdata, core_reset,
               busy, finished, timeout, cycles
    );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, streams a byte image into data memory,
// releases the core, counts run cycles until done or the cycle limit, then halts it.
module run_ctrl #(
    parameter int            AW         = 8,
    parameter int            CW         = 16,
    parameter logic [AW-1:0] LOAD_BASE  = '0,
    parameter logic [CW-1:0] MAX_CYCLES = '1
) (
    input  logic         clk,
    input  logic         reset,
    run_ctrl_if.slave    bus,
    output logic [2:0]   dbg_state_o
);
    // Load handshake: a byte moves on every rising edge where ld_valid && ld_ready.
    // ld_ready is decoded from state and depends on nothing combinational from the source.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [AW:0]   IDX_ONE = 1;
    localparam logic [CW-1:0] CYC_ONE = 1;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   idx_q, idx_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          timeout_q, timeout_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [1:0]    rst_sync_q;
    logic          rst_n;

    // Assert asynchronously, release two edges later so no flop sees a runt deassertion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            cycles_q    <= '0;
            timeout_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= LOAD_BASE;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    len_d     = bus.ld_len;
                    idx_d     = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = (bus.ld_len == '0) ? S_SETTLE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.ld_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = LOAD_BASE + idx_q[AW-1:0];
                    mem_wdata_d = bus.ld_data;
                    idx_d       = idx_q + IDX_ONE;
                    if (idx_q == len_q - IDX_ONE) state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_RUN;
            S_RUN: begin
                // A done seen on the limit cycle still counts as a clean finish.
                cycles_d = cycles_q + CYC_ONE;
                if (bus.core_done) begin
                    state_d = S_DONE;
                end else if (cycles_d == MAX_CYCLES) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ld_ready   = (state_q == S_LOAD);
    assign bus.busy       = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_RUN);
    assign bus.finished   = (state_q == S_DONE);
    assign bus.core_reset = (state_q != S_RUN);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycles     = cycles_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: two instances (load base 00 and FE, limit 20) share stimulus;
// memory writes are scored against an expected queue per instance.
module tb_run_ctrl;
    logic clk;
    logic reset;
    logic [2:0] dbg_a, dbg_b;
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];
    logic [15:0] exp_v;

    run_ctrl_if #(.AW(8), .CW(16)) a_if ();
    run_ctrl_if #(.AW(8), .CW(16)) b_if ();

    assign b_if.start     = a_if.start;
    assign b_if.ld_len    = a_if.ld_len;
    assign b_if.ld_valid  = a_if.ld_valid;
    assign b_if.ld_data   = a_if.ld_data;
    assign b_if.core_done = a_if.core_done;

    run_ctrl #(.AW(8), .CW(16), .LOAD_BASE(8'h00), .MAX_CYCLES(16'd20)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave), .dbg_state_o(dbg_a)
    );
    run_ctrl #(.AW(8), .CW(16), .LOAD_BASE(8'hFE), .MAX_CYCLES(16'd20)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave), .dbg_state_o(dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_core_reset"}, a_if.core_reset, 1);
        check({tag, "_ld_ready"},   a_if.ld_ready, 0);
        check({tag, "_mem_we"},     a_if.mem_we, 0);
        check({tag, "_mem_addr_a"}, a_if.mem_addr, 8'h00);
        check({tag, "_mem_addr_b"}, b_if.mem_addr, 8'hFE);
        check({tag, "_mem_wdata"},  a_if.mem_wdata, 0);
        check({tag, "_busy"},       a_if.busy, 0);
        check({tag, "_finished"},   a_if.finished, 0);
        check({tag, "_timeout"},    a_if.timeout, 0);
        check({tag, "_cycles"},     a_if.cycles, 0);
    endtask

    task automatic do_start(input logic [8:0] len);
        a_if.ld_len = len;
        a_if.start  = 1'b1;
        @(negedge clk);
        a_if.start  = 1'b0;
    endtask

    // Drive one byte until accepted; returns on the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] idx, input logic [7:0] d);
        logic [7:0] addr_a;
        logic [7:0] addr_b;
        int t;
        addr_a = 8'h00 + idx;
        addr_b = 8'hFE + idx;
        exp_q_a.push_back({addr_a, d});
        exp_q_b.push_back({addr_b, d});
        a_if.ld_valid = 1'b1;
        a_if.ld_data  = d;
        t = 0;
        while (!a_if.ld_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ld_ready_wait", (t < 20), 1);
        @(negedge clk);
        a_if.ld_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (a_if.mem_we) begin
            if (exp_q_a.size() == 0) check("a_wr_extra", {a_if.mem_addr, a_if.mem_wdata}, 16'h0);
            else begin
                exp_v = exp_q_a.pop_front();
                check("a_wr", {a_if.mem_addr, a_if.mem_wdata}, exp_v);
            end
        end
        if (b_if.mem_we) begin
            if (exp_q_b.size() == 0) check("b_wr_extra", {b_if.mem_addr, b_if.mem_wdata}, 16'h0);
            else begin
                exp_v = exp_q_b.pop_front();
                check("b_wr", {b_if.mem_addr, b_if.mem_wdata}, exp_v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        a_if.start     = 1'b0;
        a_if.ld_len    = '0;
        a_if.ld_valid  = 1'b0;
        a_if.ld_data   = '0;
        a_if.core_done = 1'b0;
        repeat (2) @(negedge clk);
        check_rst("por");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Load three bytes with gaps; core_done high during load must be ignored.
        a_if.core_done = 1'b1;
        do_start(9'd3);
        check("load_ld_ready", a_if.ld_ready, 1);
        check("load_busy", a_if.busy, 1);
        send_byte(8'd0, 8'hAA);
        @(negedge clk);
        send_byte(8'd1, 8'hBB);
        @(negedge clk);
        send_byte(8'd2, 8'hCC);
        a_if.core_done = 1'b0;
        check("settle_ld_ready", a_if.ld_ready, 0);
        check("settle_core_reset", a_if.core_reset, 1);
        check("settle_busy", a_if.busy, 1);
        @(negedge clk);
        check("run_core_reset", a_if.core_reset, 0);
        for (int k = 1; k <= 10; k++) begin
            a_if.start     = (k == 3);
            a_if.core_done = (k == 10);
            if (k == 5) check("run_cycles_mid", a_if.cycles, 4);
            @(negedge clk);
        end
        a_if.start     = 1'b0;
        a_if.core_done = 1'b0;
        check("done_cycles", a_if.cycles, 10);
        check("done_finished", a_if.finished, 1);
        check("done_timeout", a_if.timeout, 0);
        check("done_core_reset", a_if.core_reset, 1);
        check("done_busy", a_if.busy, 0);
        repeat (2) @(negedge clk);
        check("done_hold_cycles", a_if.cycles, 10);

        // Empty load straight from DONE.
        do_start(9'd0);
        check("empty_finished", a_if.finished, 0);
        check("empty_cycles_clr", a_if.cycles, 0);
        check("empty_core_reset", a_if.core_reset, 1);
        check("empty_ld_ready", a_if.ld_ready, 0);
        @(negedge clk);
        check("empty_run", a_if.core_reset, 0);
        a_if.core_done = 1'b1;
        @(negedge clk);
        a_if.core_done = 1'b0;
        check("empty_cycles", a_if.cycles, 1);
        check("empty_done", a_if.finished, 1);

        // Cycle limit with core_done held low.
        do_start(9'd0);
        @(negedge clk);
        repeat (19) @(negedge clk);
        check("to_pre_finished", a_if.finished, 0);
        check("to_pre_cycles", a_if.cycles, 19);
        @(negedge clk);
        check("to_finished", a_if.finished, 1);
        check("to_cycles", a_if.cycles, 20);
        check("to_timeout", a_if.timeout, 1);
        @(negedge clk);
        check("to_hold_cycles", a_if.cycles, 20);
        check("to_hold_timeout", a_if.timeout, 1);

        // core_done on the limit cycle wins over the timeout.
        do_start(9'd0);
        check("lim_timeout_clr", a_if.timeout, 0);
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            a_if.core_done = (k == 20);
            @(negedge clk);
        end
        a_if.core_done = 1'b0;
        check("lim_cycles", a_if.cycles, 20);
        check("lim_timeout", a_if.timeout, 0);
        check("lim_finished", a_if.finished, 1);

        // Abort a load after two of five bytes.
        do_start(9'd5);
        check("ab_cycles_clr", a_if.cycles, 0);
        check("ab_finished_clr", a_if.finished, 0);
        send_byte(8'd0, 8'h11);
        send_byte(8'd1, 8'h22);
        #2;
        reset = 1'b0;
        a_if.ld_valid = 1'b1;
        a_if.ld_data  = 8'h33;
        #1;
        check_rst("abort_load");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("ab_idle_ld_ready", a_if.ld_ready, 0);
        a_if.ld_valid = 1'b0;

        // Fresh load: instance b wraps FE, FF, 00.
        do_start(9'd3);
        send_byte(8'd0, 8'h44);
        send_byte(8'd1, 8'h55);
        send_byte(8'd2, 8'h66);
        @(negedge clk);
        a_if.core_done = 1'b1;
        @(negedge clk);
        a_if.core_done = 1'b0;
        check("wrap_cycles", a_if.cycles, 1);
        check("wrap_finished", b_if.finished, 1);

        // Abort mid-run.
        do_start(9'd0);
        @(negedge clk);
        check("ar_core_reset_low", a_if.core_reset, 0);
        #2;
        reset = 1'b0;
        #1;
        check_rst("abort_run");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("a_wr_left", exp_q_a.size(), 0);
        check("b_wr_left", exp_q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sits directly upstream of the CPU core. It holds the core in reset and streams a byte image into data memory over a valid/ready port. It then releases the core, counts execution cycles until the core raises `done` (or a timeout expires), and halts the core again. The core's data memory write port is muxed to this block whenever `core_reset` is high.

## Interface
- `AW`, 8: data memory address width.
- `CW`, 16: cycle counter width.
- `LOAD_BASE`, 8'h00: first data memory address written during load.
- `MAX_CYCLES`, 16'd65535: run cycle limit before timeout; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load and run; sampled in IDLE and DONE only.
- `ld_len` in AW+1: number of bytes to load (0..2^AW); latched on accepted `start`.
- `ld_valid` in 1: load byte valid.
- `ld_data` in 8: load byte.
- `ld_ready` out 1: load byte accepted when `ld_valid && ld_ready`.
- `mem_we` out 1: data memory write enable, registered.
- `mem_addr` out AW: data memory write address, registered.
- `mem_wdata` out 8: data memory write data, registered.
- `core_reset` out 1: active-high reset to the core; low only in RUN.
- `core_done` in 1: core completion flag; sampled only in RUN.
- `busy` out 1: high in LOAD, SETTLE, RUN.
- `finished` out 1: high in DONE.
- `timeout` out 1: set when leaving RUN on the cycle limit; held through DONE.
- `cycles` out CW: run cycle count; holds its value in DONE.

## Operation
- States are IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE:
  - `core_reset`=1, `ld_ready`=0.
  - `start` with `ld_len`≠0 → LOAD.
  - `start` with `ld_len`=0 → SETTLE.
  - On accepted `start`, clear `cycles`, `timeout`, and the byte index.
- LOAD:
  - `ld_ready`=1.
  - Each handshake registers `mem_we`=1, `mem_addr`=(LOAD_BASE+index) mod 2^AW, `mem_wdata`=`ld_data`, then increments the index.
  - With no handshake, `mem_we`=0 next cycle.
  - Handshake on byte `ld_len`-1 → SETTLE, with `ld_ready` low from that transition.
  - `ld_valid` gaps of any length are legal.
- SETTLE:
  - Exactly one cycle; the final registered write lands; `core_reset` stays 1.
  - Always → RUN.
- RUN:
  - `core_reset`=0; `cycles` increments every RUN cycle, including the cycle `core_done` is sampled high.
  - `core_done`=1 → DONE.
  - Otherwise, `cycles` reaching MAX_CYCLES → DONE with `timeout`=1.
  - If `core_done` and the limit coincide, `core_done` wins and `timeout`=0.
- DONE:
  - `core_reset`=1, `finished`=1; `cycles` and `timeout` hold.
  - `start` restarts exactly as from IDLE.
- `start` in LOAD, SETTLE, or RUN is ignored. `core_done` outside RUN is ignored.
- Address wraps modulo 2^AW. `ld_len`=2^AW writes every location once.
- `cycles` never exceeds MAX_CYCLES and does not wrap.

## Timing
- Reset values (asserted asynchronously on `reset`=0): state IDLE, `core_reset`=1, `ld_ready`=0, `mem_we`=0, `mem_addr`=LOAD_BASE, `mem_wdata`=0, `busy`=0, `finished`=0, `timeout`=0, `cycles`=0.
- Reset deassertion is synchronized internally, so the first state change occurs ≥1 edge after release.
- Reset mid-LOAD or mid-RUN aborts immediately: no further writes, and `core_reset` returns to 1 at once.
- `start` accepted at edge N → `ld_ready`=1 after edge N (or SETTLE if `ld_len`=0).
- Handshake at edge N → `mem_we`=1 for the cycle after edge N.
- Last handshake at edge N → SETTLE after N, RUN after N+1, so `core_reset` falls after edge N+1.
- `core_done` sampled at edge M → `finished`=1 and `core_reset`=1 after edge M.
- All outputs are registered except `ld_ready`, `busy`, `finished`, and `core_reset`, which are decoded from state.

## Test plan
- Reset: pulse `reset`=0 mid-cycle → all outputs at reset values immediately, with no clock edge needed.
- Load and run: `ld_len`=3, bytes AA/BB/CC with one idle cycle between each → writes (0,AA), (1,BB), (2,CC) one cycle after each handshake; one SETTLE cycle; `core_done` on the 10th RUN cycle → `cycles`=10, `finished`=1, `timeout`=0, `core_reset`=1.
- Empty load: `ld_len`=0, `start` → no `mem_we`; RUN after two edges; `core_done` on the 1st RUN cycle → `cycles`=1.
- Timeout: MAX_CYCLES=20, `core_done` tied low → DONE with `cycles`=20 and `timeout`=1. Separately, `core_done` on cycle 20 → `timeout`=0.
- Abort: `reset` low after 2 of 5 bytes → no further writes, `ld_ready`=0. A fresh `start` with `LOAD_BASE`=8'hFE and `ld_len`=3 → addresses FE, FF, 00.
- Ignored inputs: `start` during RUN and `core_done` during LOAD → no effect. `start` in DONE → `cycles`, `timeout`, and `finished` clear and a new load begins.
